// File: rtl/serv_uart_rx_wb.sv
// Wishbone-readable 8N1 UART receiver with a small receive FIFO.
// Define SERV_RX_IRQ_EN to enable irq_o and the STATUS irq_en bit.
module serv_uart_rx_wb #(
    parameter int unsigned DIV_RESET  = 217,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        rx_i,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic        rx_s1_q, rx_s2_q, rxs;
    logic [2:0]  st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [15:0] div_q, div_d;
    logic        push, ferr_set;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] count_q, count_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d, rdata;
    logic        req, rd, wr, pop, do_push, full, not_empty, irq_en;
    logic [1:0]  reg_sel;

    assign rxs       = rx_s2_q;
    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);
    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign rd        = req & ~wbs_we_i;
    assign wr        = req & wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];
    assign pop       = rd & (reg_sel == 2'd0) & not_empty;
    // A push into a full FIFO still lands if a pop frees the slot this cycle.
    assign do_push   = push & (~full | pop);

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (st_q)
            S_IDLE: if (!rxs) begin
                cnt_d = {1'b0, div_q[15:1]};
                st_d  = S_START;
            end
            S_START: if (cnt_q == '0) begin
                if (rxs) begin
                    st_d = S_IDLE;
                end else begin
                    cnt_d = div_q - 16'd1;
                    idx_d = 3'd0;
                    st_d  = S_DATA;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            S_DATA: if (cnt_q == '0) begin
                sh_d  = {rxs, sh_q[7:1]};
                cnt_d = div_q - 16'd1;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) st_d = S_STOP;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            S_STOP: if (cnt_q == '0) begin
                if (rxs) begin
                    push = 1'b1;
                    st_d = S_IDLE;
                end else begin
                    ferr_set = 1'b1;
                    st_d     = S_WAIT;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            S_WAIT: if (rxs) st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d = div_q;
        if (wr && reg_sel == 2'd2) begin
            if (wbs_sel_i[0]) div_d[7:0]  = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) div_d[15:8] = wbs_dat_i[15:8];
            if (div_d < 16'd4) div_d = 16'd4;
        end
    end

    always_comb begin
        wp_d    = do_push ? wp_q + AW'(1) : wp_q;
        rp_d    = pop ? rp_q + AW'(1) : rp_q;
        count_d = count_q;
        if (do_push && !pop) count_d = count_q + ONE_CNT;
        else if (pop && !do_push) count_d = count_q - ONE_CNT;
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (wr && reg_sel == 2'd1) begin
            if (wbs_dat_i[2]) ovr_d  = 1'b0;
            if (wbs_dat_i[3]) ferr_d = 1'b0;
        end
        if (push && full && !pop) ovr_d = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            2'd0: rdata = not_empty ? {24'd0, mem_q[rp_q]} : 32'd0;
            2'd1: rdata = {27'd0, irq_en, ferr_q, ovr_q, full, not_empty};
            2'd2: rdata = {16'd0, div_q};
            2'd3: rdata = 32'd0;
        endcase
        ack_d = req;
        dat_d = rd ? rdata : 32'd0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            st_q    <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            div_q   <= 16'(DIV_RESET);
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem_q[wp_q] <= sh_q;
    end

`ifdef SERV_RX_IRQ_EN
    logic irq_en_q, irq_q;
    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && reg_sel == 2'd1) irq_en_q <= wbs_dat_i[4];
            irq_q <= irq_en_q & (not_empty | ovr_q | ferr_q);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0],
                           wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_dat_i[4]};
endmodule

// File: tb/tb_serv_uart_rx_wb.sv
// Directed bench for serv_uart_rx_wb: register table plus UART frame sequences.
// Build with SERV_RX_IRQ_EN defined to exercise the interrupt path.
module tb_serv_uart_rx_wb;
`ifdef SERV_RX_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic [31:0] rdat;
    logic        ack, irq;
    logic        rx = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serv_uart_rx_wb dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_dat_o(rdat),
        .wbs_ack_o(ack),
        .rx_i     (rx),
        .irq_o    (irq)
    );

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[19];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = {28'd0, a}; wdat = d; sel = s;
        @(negedge clk);
        check("ack", {31'd0, ack}, 32'd1);
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        logic [31:0] q;
        bus(1'b0, a, 32'd0, 4'hF, q);
        check(name, q, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(1'b1, a, d, 4'hF, q);
    endtask

    // Frame bits change on negedges; stop-bit sample/push lands on the 155th posedge.
    task automatic send(input logic [7:0] b, input logic stop,
                        input bit rd_at_stop, input logic [7:0] exp_rd,
                        input bit chk_irq);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int j = 0; j < 160; j++) begin
            @(negedge clk);
            rx = fr[j/16];
            if (rd_at_stop && j == 155) begin
                cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
            end
            if (rd_at_stop && j == 156) begin
                check("ack_at_stop", {31'd0, ack}, 32'd1);
                check("data_at_stop", {24'd0, rdat[7:0]}, {24'd0, exp_rd});
                cyc = 1'b0; stb = 1'b0;
            end
            if (chk_irq && j == 156) check("irq_same_cycle", {31'd0, irq}, 32'd0);
            if (chk_irq && j == 157) check("irq_next_cycle", {31'd0, irq}, {31'd0, IRQ});
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] q;
        vt[0]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'd217};
        vt[1]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0};
        vt[2]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0};
        vt[3]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0};
        vt[4]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};
        vt[5]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 4'hF, 32'h0};
        vt[6]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};
        vt[7]  = '{1'b1, 4'h0, 32'h000000FF, 4'hF, 32'h0};
        vt[8]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0};
        vt[9]  = '{1'b1, 4'h8, 32'h00000001, 4'h1, 32'h0};
        vt[10] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h4};
        vt[11] = '{1'b1, 4'h8, 32'h00001234, 4'h2, 32'h0};
        vt[12] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h1204};
        vt[13] = '{1'b1, 4'h8, 32'hABCD0010, 4'hF, 32'h0};
        vt[14] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h10};
        vt[15] = '{1'b1, 4'h4, 32'h00000010, 4'hF, 32'h0};
        vt[16] = '{1'b0, 4'h4, 32'h0,        4'hF, {27'd0, IRQ, 4'd0}};
        vt[17] = '{1'b1, 4'h4, 32'h00000000, 4'hF, 32'h0};
        vt[18] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            bus(vt[i].w, vt[i].a, vt[i].d, vt[i].s, q);
            if (!vt[i].w) check($sformatf("vec%0d", i), q, vt[i].exp);
        end

        send(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
        rd(4'h4, 32'h1, "a5_status");
        rd(4'h0, 32'hA5, "a5_data");
        rd(4'h4, 32'h0, "a5_status_after");

        for (int i = 0; i < 9; i++) send(8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        rd(4'h4, 32'h7, "ovr_status");
        for (int i = 0; i < 8; i++) rd(4'h0, 32'(i), $sformatf("ovr_data%0d", i));
        rd(4'h4, 32'h4, "ovr_drained");
        wr(4'h4, 32'h4);
        rd(4'h4, 32'h0, "ovr_cleared");

        @(negedge clk); rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        rd(4'h4, 32'h0, "glitch_status");
        rd(4'h0, 32'h0, "glitch_data");

        send(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
        rd(4'h4, 32'h8, "ferr_status");
        wr(4'h4, 32'h8);
        rd(4'h4, 32'h0, "ferr_cleared");
        send(8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
        rd(4'h4, 32'h1, "x55_status");
        rd(4'h0, 32'h55, "x55_data");

        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        rd(4'h4, 32'h3, "full_status");
        send(8'h18, 1'b1, 1'b1, 8'h10, 1'b0);
        rd(4'h4, 32'h3, "full_pushpop_status");
        for (int i = 1; i < 9; i++)
            rd(4'h0, 32'h10 + 32'(i), $sformatf("full_data%0d", i));
        rd(4'h4, 32'h0, "full_drained");

        wr(4'h4, 32'h10);
        send(8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        bus(1'b0, 4'h0, 32'd0, 4'hF, q);
        check("irq_data", q, 32'h5A);
        check("irq_at_pop", {31'd0, irq}, {31'd0, IRQ});
        @(negedge clk);
        check("irq_after_pop", {31'd0, irq}, 32'd0);

        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            rx = (j < 16) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        @(negedge clk);
        check("rst_no_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("rst_no_ack2", {31'd0, ack}, 32'd0);
        repeat (200) @(negedge clk);
        rd(4'h8, 32'd217, "rst2_div");
        rd(4'h4, 32'h0, "rst2_status");
        rd(4'h0, 32'h0, "rst2_data");
        check("rst2_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serv_uart_rx_wb.md
Name: serv_uart_rx_wb

Overview:
- Wishbone-readable UART receiver that captures the serial TX stream a SERV core drives on its user IO pins.
- Gives the Caravel management SoC a way to read SERV console output without external hardware.
- Sits inside user_project_wrapper on the wbs_* slave bus. Its rx input is looped from a SERV io_out bit.
- Deserialises 8N1 frames, buffers them in a small FIFO and exposes data, status and divisor registers.

Parameters:
- DIV_RESET, 217, reset value of the baud divisor in clocks per bit (25 MHz / 115200).
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of two, minimum 2.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; only bits [1:0] are used, by DIV.
- wbs_adr_i  in  32  address; bits [3:2] select the register, other bits are ignored.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  transfer acknowledge.
- rx_i  in  1  asynchronous serial input; idles high.
- irq_o  out  1  interrupt to user_irq[0].

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, FIFO empty, sticky flags 0, DIV=DIV_RESET, RX state IDLE, synchroniser flops 1.
- Bus timing:
  - wbs_ack_o pulses for 1 cycle, on the cycle after cyc&stb&!ack is sampled. Latency is 1, so no back-to-back ack.
  - wbs_dat_o is valid with ack and is 0 when no ack is asserted.
- Register map, word offsets:
  - 0x0 DATA (RO): [7:0] is the FIFO head. A read pops one entry. Reading an empty FIFO returns 0 and does not pop. Writes are ignored.
  - 0x4 STATUS: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [4] irq_en (RW).
    - Writing 1 to bit [2] or [3] clears that flag; bit [4] is written directly.
  - 0x8 DIV (RW): [15:0], byte-lane writes honoured. A resulting value below 4 is stored as 4.
  - 0xC: reads 0, writes ignored.
- Input synchronisation: rx_i passes through a 2-flop synchroniser; all RX logic uses the synchronised bit rxs.
- RX state machine (bit counter cnt, bit index idx):
  - IDLE: when rxs=0, load cnt=DIV>>1 and go to START.
  - START: when cnt reaches 0, sample. rxs=1 is a glitch: return to IDLE with no flag. Otherwise reload cnt=DIV-1, idx=0, go to DATA.
  - DATA: at each cnt=0, shift rxs into the byte LSB-first and reload cnt. After idx=7, go to STOP.
  - STOP: at cnt=0, sample.
    - rxs=1: push the byte, then go to IDLE.
    - rxs=0: set frame_err and discard the byte. Stay in STOP-wait until rxs=1, then go to IDLE; this prevents re-triggering on a break.
- Push while full:
  - A push with the FIFO full and no pop in the same cycle drops the byte and sets overrun.
  - A push and pop in the same cycle when full are both performed; count is unchanged and no overrun.
- A push and pop in the same cycle on a non-empty FIFO leave count unchanged. A push into an empty FIFO is readable on the next cycle.
- DIV changes take effect at the next cnt reload; a frame in flight is not restarted.
- Pointers are log2(FIFO_DEPTH)-bit and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame or mid-bus-cycle: everything returns to reset values on the next edge. A partial byte is lost and no ack is issued.

Optional Feature:
- Macro: SERV_RX_IRQ_EN.
- Defined: irq_o is a registered (irq_en & (not_empty | overrun | frame_err)), so it updates 1 cycle after its cause.
- Undefined: irq_o is tied 0, STATUS[4] reads 0 and its writes are ignored.

Test Plan:
- After reset: read 0x8 -> 217; read 0x4 -> 0; read 0x0 -> 0, FIFO still empty.
- Write DIV=16, send 0xA5 as 8N1 at 16 clk/bit -> STATUS=0x1; DATA=0xA5; STATUS then reads 0x0.
- Send 9 bytes 0x00..0x08 with no reads (DEPTH 8) -> STATUS full and overrun set (0x7); DATA returns 0x00..0x07 in order; 0x08 lost. Write 0x4 with data 0x4 -> overrun cleared.
- Low pulse of 4 clocks at DIV=16 -> no byte and no flags. A frame 0x3C with stop bit held low -> frame_err=1 and FIFO empty. Then a valid 0x55 -> received correctly.
- FIFO full and DATA read coinciding with the stop-bit push -> no overrun; count stays 8; order preserved.
- With SERV_RX_IRQ_EN, irq_en=1, one byte received -> irq_o=1 one cycle after not_empty; DATA read -> irq_o=0 the following cycle. Without the macro, irq_o stays 0 throughout.
